// File: rtl/fp_add_control.sv
// ============================================================================
// Module   : fp_add_control
// Brief    : Sequencing controller for a floating-point adder datapath.
//            It walks the datapath through operand alignment, mantissa add,
//            normalization and an optional rounding step.
// Options  : define ROUND_EN to enable the ROUND state and one re-normalization pass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package controlpkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DISSR = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } StateType;
endpackage

module fp_add_control #(
    parameter  int EXPBITS      = 8,
    parameter  int MANTISSABITS = 23,
    localparam int IW           = $clog2(MANTISSABITS)
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 Go,
    input  logic [EXPBITS-1:0]   ExpDiff,
    input  logic                 ExpSign,
    input  logic                 FFOValid,
    input  logic [IW-1:0]        FFOIndex,
    input  logic                 RoundCarry,
    output logic                 SelExpMux,
    output logic                 SelSRMuxL,
    output logic                 SelSRMuxG,
    output logic                 ShiftRightEnable,
    output logic [IW-1:0]        ShiftRightAmount,
    output logic                 SREn,
    output logic                 SLEn,
    output logic                 NoShift,
    output logic                 IncrEn,
    output logic                 DecrEn,
    output logic [IW-1:0]        ShiftAmount,
    output logic                 SelExpMuxR,
    output logic                 SelManMuxR,
    output logic                 RoundEn,
    output logic                 Busy,
    output logic                 Done,
    output controlpkg::StateType State
);

    import controlpkg::*;

    // Largest useful alignment shift: a shift past the hidden bit and guard
    // position clears the mantissa, so larger differences saturate here.
    localparam int SR_MAX = MANTISSABITS + 1;

    StateType           state_q, state_d;
    logic [EXPBITS-1:0] exp_diff_q, exp_diff_d;
    logic               exp_sign_q, exp_sign_d;
    logic               repass_q, repass_d;

`ifndef ROUND_EN
    // Rounding carry has no consumer when the rounding pass is compiled out.
    logic unused_round_carry;
    assign unused_round_carry = RoundCarry;
`endif

    // State register and operand capture, cleared asynchronously by ResetN.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= IDLE;
            exp_diff_q <= '0;
            exp_sign_q <= 1'b0;
            repass_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_diff_q <= exp_diff_d;
            exp_sign_q <= exp_sign_d;
            repass_q   <= repass_d;
        end
    end

    // Next-state logic; operands are captured only when a new operation starts.
    always_comb begin
        state_d    = state_q;
        exp_diff_d = exp_diff_q;
        exp_sign_d = exp_sign_q;
        repass_d   = repass_q;
        case (state_q)
            IDLE: begin
                repass_d = 1'b0;
                if (Go) begin
                    exp_diff_d = ExpDiff;
                    exp_sign_d = ExpSign;
                    state_d    = DISSR;
                end
            end
            DISSR: state_d = ADD;
            ADD:   state_d = NORM;
`ifdef ROUND_EN
            NORM:  state_d = ROUND;
            ROUND: begin
                // A rounding overflow gets exactly one extra normalization pass.
                if (RoundCarry && !repass_q) begin
                    repass_d = 1'b1;
                    state_d  = NORM;
                end else begin
                    state_d = DONE;
                end
            end
`else
            NORM:  state_d = DONE;
            ROUND: state_d = IDLE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the current state; every control defaults to 0.
    always_comb begin
        SelExpMux        = 1'b0;
        SelSRMuxL        = 1'b0;
        SelSRMuxG        = 1'b0;
        ShiftRightEnable = 1'b0;
        ShiftRightAmount = '0;
        SREn             = 1'b0;
        SLEn             = 1'b0;
        NoShift          = 1'b0;
        IncrEn           = 1'b0;
        DecrEn           = 1'b0;
        ShiftAmount      = '0;
        SelExpMuxR       = 1'b0;
        SelManMuxR       = 1'b0;
        RoundEn          = 1'b0;
        Busy             = (state_q != IDLE);
        Done             = 1'b0;
        case (state_q)
            DISSR: begin
                // The operand with the smaller exponent is shifted right.
                SelExpMux        = exp_sign_q;
                SelSRMuxG        = exp_sign_q;
                SelSRMuxL        = ~exp_sign_q;
                ShiftRightEnable = (exp_diff_q != '0);
                if (int'(exp_diff_q) > SR_MAX) begin
                    ShiftRightAmount = IW'(SR_MAX);
                end else begin
                    ShiftRightAmount = IW'(exp_diff_q);
                end
            end
            NORM: begin
                if (!FFOValid) begin
                    NoShift = 1'b1;
                end else if (int'(FFOIndex) == MANTISSABITS + 1) begin
                    // Carry out of the add: one right shift, exponent up.
                    SREn        = 1'b1;
                    IncrEn      = 1'b1;
                    ShiftAmount = IW'(1);
                end else if (int'(FFOIndex) == MANTISSABITS) begin
                    NoShift = 1'b1;
                end else begin
                    // Cancellation: bring the leading one back to the hidden bit.
                    SLEn        = 1'b1;
                    DecrEn      = 1'b1;
                    ShiftAmount = IW'(MANTISSABITS - int'(FFOIndex));
                end
`ifdef ROUND_EN
                SelExpMuxR = repass_q;
                SelManMuxR = repass_q;
`endif
            end
`ifdef ROUND_EN
            ROUND: RoundEn = 1'b1;
`endif
            DONE: Done = 1'b1;
            default: ;
        endcase
    end

    assign State = state_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_control.sv
// ============================================================================
// Module   : tb_fp_add_control
// Brief    : Self-checking bench for fp_add_control with a phase-level
//            reference model of the expected control outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_add_control;
    import controlpkg::*;

    localparam int EB = 8;
    localparam int MB = 23;
    localparam int IW = 5;

    logic          Clock = 1'b0;
    logic          ResetN = 1'b0;
    logic          Go = 1'b0;
    logic [EB-1:0] ExpDiff = '0;
    logic          ExpSign = 1'b0;
    logic          FFOValid = 1'b0;
    logic [IW-1:0] FFOIndex = '0;
    logic          RoundCarry = 1'b0;

    logic          SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightEnable;
    logic [IW-1:0] ShiftRightAmount, ShiftAmount;
    logic          SREn, SLEn, NoShift, IncrEn, DecrEn;
    logic          SelExpMuxR, SelManMuxR, RoundEn, Busy, Done;
    StateType      State;

    int checks = 0;
    int errors = 0;
    int opn    = 0;

    fp_add_control #(.EXPBITS(EB), .MANTISSABITS(MB)) dut (
        .Clock(Clock), .ResetN(ResetN), .Go(Go), .ExpDiff(ExpDiff), .ExpSign(ExpSign),
        .FFOValid(FFOValid), .FFOIndex(FFOIndex), .RoundCarry(RoundCarry),
        .SelExpMux(SelExpMux), .SelSRMuxL(SelSRMuxL), .SelSRMuxG(SelSRMuxG),
        .ShiftRightEnable(ShiftRightEnable), .ShiftRightAmount(ShiftRightAmount),
        .SREn(SREn), .SLEn(SLEn), .NoShift(NoShift), .IncrEn(IncrEn), .DecrEn(DecrEn),
        .ShiftAmount(ShiftAmount), .SelExpMuxR(SelExpMuxR), .SelManMuxR(SelManMuxR),
        .RoundEn(RoundEn), .Busy(Busy), .Done(Done), .State(State)
    );

    always #5 Clock = ~Clock;

    // Observed outputs packed as {state, done, busy, round_en, sel_man_r,
    // sel_exp_r, shift_amt, decr, incr, noshift, sl, sr, sr_amt, sr_en,
    // sel_g, sel_l, sel_exp}.
    function automatic logic [26:0] observe();
        return {State, Done, Busy, RoundEn, SelManMuxR, SelExpMuxR, ShiftAmount,
                DecrEn, IncrEn, NoShift, SLEn, SREn, ShiftRightAmount,
                ShiftRightEnable, SelSRMuxG, SelSRMuxL, SelExpMux};
    endfunction

    // Expected outputs for one phase of an operation, from the datapath rules.
    function automatic logic [26:0] model(StateType ph, int ed, bit es, bit fv,
                                          int fi, bit rp);
        bit       sel_exp = 0, sel_l = 0, sel_g = 0, sr_en = 0;
        bit       sr = 0, sl = 0, ns = 0, inc = 0, dec = 0, rx = 0, ren = 0;
        int       sra = 0, sa = 0;
        logic [4:0] sra5, sa5;
        logic [2:0] st;
        if (ph == DISSR) begin
            sel_exp = es;
            sel_g   = es;
            sel_l   = !es;
            sr_en   = (ed != 0);
            sra     = (ed > MB + 1) ? MB + 1 : ed;
        end
        if (ph == NORM) begin
            if (!fv) ns = 1;
            else if (fi == MB + 1) begin sr = 1; inc = 1; sa = 1; end
            else if (fi == MB) ns = 1;
            else begin sl = 1; dec = 1; sa = MB - fi; end
`ifdef ROUND_EN
            rx = rp;
`endif
        end
`ifdef ROUND_EN
        if (ph == ROUND) ren = 1;
`endif
        sra5 = 5'(sra);
        sa5  = 5'(sa);
        st   = ph;
        return {st, bit'(ph == DONE), bit'(ph != IDLE), ren, rx, rx, sa5,
                dec, inc, ns, sl, sr, sra5, sr_en, sel_g, sel_l, sel_exp};
    endfunction

    task automatic chk(string tag, logic [26:0] obs, logic [26:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One full operation from IDLE; inputs other than the FFO/carry are
    // scrambled while busy to show they are ignored.
    task automatic run_op(int ed, bit es, bit fv, int fi, bit rc, bit hold);
        StateType ph[$];
        bit       rp[$];
        opn++;
        ph = '{DISSR, ADD, NORM};
        rp = '{0, 0, 0};
`ifdef ROUND_EN
        ph.push_back(ROUND); rp.push_back(0);
        if (rc) begin
            ph.push_back(NORM);  rp.push_back(1);
            ph.push_back(ROUND); rp.push_back(1);
        end
`endif
        ph.push_back(DONE); rp.push_back(0);
        Go = 1'b1; ExpDiff = EB'(ed); ExpSign = es;
        FFOValid = fv; FFOIndex = IW'(fi); RoundCarry = rc;
        foreach (ph[i]) begin
            @(posedge Clock); #1;
            if (!hold) begin
                Go = 1'($urandom); ExpDiff = EB'($urandom); ExpSign = 1'($urandom);
            end
            #1;
            chk($sformatf("op%0d_%s_%0d", opn, ph[i].name(), i), observe(),
                model(ph[i], ed, es, fv, fi, rp[i]));
        end
        @(posedge Clock); #2;
        chk($sformatf("op%0d_idle", opn), observe(), model(IDLE, 0, 0, 0, 0, 0));
        if (!hold) Go = 1'b0;
    endtask

    initial begin
        // Reset holds everything at zero without any clock edge.
        #2;
        chk("reset_async", observe(), '0);
        @(posedge Clock); #3; ResetN = 1'b1;
        @(posedge Clock); #2;
        chk("reset_release_idle", observe(), model(IDLE, 0, 0, 0, 0, 0));

        // Directed operations covering alignment and normalization boundaries.
        run_op(5,   1, 1, 23, 0, 0);
        run_op(0,   0, 1, 24, 0, 0);
        run_op(200, 1, 1, 10, 0, 0);
        run_op(24,  0, 0, 3,  0, 0);
        run_op(25,  1, 1, 0,  1, 0);
        run_op(3,   0, 1, 24, 1, 0);

        // Randomized operations.
        for (int n = 0; n < 20; n++) begin
            run_op(int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, MB + 1)), 1'($urandom), 0);
        end

        // Go held high: back-to-back operations, one IDLE cycle between.
        run_op(7,  0, 1, 12, 0, 1);
        run_op(7,  0, 1, 12, 0, 1);
        Go = 1'b0;
        @(posedge Clock); #2;
        chk("hold_release_idle", observe(), model(IDLE, 0, 0, 0, 0, 0));

        // Reset asserted during NORM aborts the operation immediately.
        Go = 1'b1; ExpDiff = 8'd9; ExpSign = 1'b1; FFOValid = 1'b1; FFOIndex = 5'd5;
        RoundCarry = 1'b0;
        @(posedge Clock); #1; Go = 1'b0; #1;
        chk("abort_dissr", observe(), model(DISSR, 9, 1, 1, 5, 0));
        @(posedge Clock); #2;
        chk("abort_add", observe(), model(ADD, 9, 1, 1, 5, 0));
        @(posedge Clock); #2;
        chk("abort_norm", observe(), model(NORM, 9, 1, 1, 5, 0));
        #1; ResetN = 1'b0; #1;
        chk("abort_async_zero", observe(), '0);
        for (int c = 0; c < 3; c++) begin
            @(posedge Clock); #2;
            chk($sformatf("abort_held_%0d", c), observe(), '0);
        end
        #1; ResetN = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clock); #2;
            chk($sformatf("abort_no_done_%0d", c), observe(), model(IDLE, 0, 0, 0, 0, 0));
        end
        run_op(30, 0, 1, 24, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
